// File: rtl/hop_seq_ctrl.sv
// Frequency-hop sequencer: local-sync preamble, then per-hop sync/blank and TX intervals, driven from a writable hop-code table.
// Optional HOP_TX watchdog (err output) is compiled in when HOP_SEQ_TIMEOUT_EN is defined.

module hop_seq_ctrl #(
  parameter int PHASE_WIDTH    = 24,
  parameter int CODE_WIDTH     = 32,
  parameter int HOP_ADDR_WIDTH = 6,
  parameter int SYNC_LEN_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [HOP_ADDR_WIDTH:0]   cfg_num_hops,
  input  logic [SYNC_LEN_WIDTH-1:0] cfg_sync_len,
  input  logic [PHASE_WIDTH-1:0]    cfg_start_ph_inc,
  input  logic [PHASE_WIDTH-1:0]    cfg_dph_inc,
  input  logic                      tbl_wr_en,
  input  logic [HOP_ADDR_WIDTH-1:0] tbl_wr_addr,
  input  logic [CODE_WIDTH-1:0]     tbl_wr_data,
  input  logic                      hop_done,
  output logic [1:0]                state,
  output logic [HOP_ADDR_WIDTH-1:0] hop_n,
  output logic [PHASE_WIDTH-1:0]    hop_phase_inc,
  output logic [CODE_WIDTH-1:0]     hop_code,
  output logic                      hop_rst,
  output logic                      tx_blank,
  output logic                      sync_out,
  output logic                      busy,
  output logic                      seq_done,
  output logic                      err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOC_SYNC = 2'd1,
    S_HOP_SYNC = 2'd2,
    S_HOP_TX   = 2'd3
  } state_e;

  localparam int TBL_DEPTH = 2 ** HOP_ADDR_WIDTH;
  localparam logic [HOP_ADDR_WIDTH:0]   MAX_HOPS = (HOP_ADDR_WIDTH + 1)'(TBL_DEPTH);
  localparam logic [SYNC_LEN_WIDTH-1:0] MIN_SYNC = SYNC_LEN_WIDTH'(4);

  state_e                    state_q, state_d;
  logic [SYNC_LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [HOP_ADDR_WIDTH-1:0] hop_n_q, hop_n_d;
  logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
  logic [SYNC_LEN_WIDTH-1:0] sync_len_q, sync_len_d;
  logic [HOP_ADDR_WIDTH:0]   num_hops_q, num_hops_d;
  logic [PHASE_WIDTH-1:0]    start_ph_q, start_ph_d;
  logic [PHASE_WIDTH-1:0]    dph_q, dph_d;
  logic                      hop_rst_q, hop_rst_d;
  logic                      seq_done_q, seq_done_d;
  logic [CODE_WIDTH-1:0]     code_q;
  logic [CODE_WIDTH-1:0]     tbl_q [TBL_DEPTH];

  logic [SYNC_LEN_WIDTH-1:0] sync_len_eff;
  logic [HOP_ADDR_WIDTH:0]   num_hops_eff;
  logic                      more_hops;
  logic                      wd_hit;

  assign sync_len_eff = (cfg_sync_len < MIN_SYNC) ? MIN_SYNC : cfg_sync_len;
  assign num_hops_eff = (cfg_num_hops == '0)      ? (HOP_ADDR_WIDTH + 1)'(1) :
                        (cfg_num_hops > MAX_HOPS) ? MAX_HOPS : cfg_num_hops;
  // hop_n < num_hops-1, evaluated one bit wider so num_hops = 2**HOP_ADDR_WIDTH fits
  assign more_hops = ({1'b0, hop_n_q} + (HOP_ADDR_WIDTH + 1)'(1)) < num_hops_q;

`ifdef HOP_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  assign wd_hit = (state_q == S_HOP_TX) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign wd_d   = (state_q == S_HOP_TX) ? wd_q + WD_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    err_d = err_q;
    if (!stop) begin
      if (state_q == S_IDLE && start) err_d = 1'b0;
      else if (wd_hit && !hop_done)   err_d = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Next state and datapath; stop outranks start, hop_done and the watchdog.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    hop_n_d    = hop_n_q;
    phase_d    = phase_q;
    sync_len_d = sync_len_q;
    num_hops_d = num_hops_q;
    start_ph_d = start_ph_q;
    dph_d      = dph_q;
    seq_done_d = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hop_n_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          sync_len_d = sync_len_eff;
          num_hops_d = num_hops_eff;
          start_ph_d = cfg_start_ph_inc;
          dph_d      = cfg_dph_inc;
          hop_n_d    = '0;
          phase_d    = cfg_start_ph_inc;
          cnt_d      = sync_len_eff - SYNC_LEN_WIDTH'(1);
          state_d    = S_LOC_SYNC;
        end
        S_LOC_SYNC: if (cnt_q == '0) begin
          cnt_d   = sync_len_q - SYNC_LEN_WIDTH'(1);
          state_d = S_HOP_SYNC;
        end else begin
          cnt_d = cnt_q - SYNC_LEN_WIDTH'(1);
        end
        S_HOP_SYNC: if (cnt_q == '0) begin
          state_d = S_HOP_TX;
        end else begin
          cnt_d = cnt_q - SYNC_LEN_WIDTH'(1);
        end
        S_HOP_TX: if (hop_done) begin
          cnt_d = sync_len_q - SYNC_LEN_WIDTH'(1);
          if (more_hops) begin
            hop_n_d = hop_n_q + HOP_ADDR_WIDTH'(1);
            phase_d = phase_q + dph_q;
            state_d = S_HOP_SYNC;
          end else if (loop_en) begin
            hop_n_d = '0;
            phase_d = start_ph_q;
            state_d = S_LOC_SYNC;
          end else begin
            cnt_d      = '0;
            state_d    = S_IDLE;
            seq_done_d = 1'b1;
          end
        end else if (wd_hit) begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign hop_rst_d = (state_d == S_HOP_SYNC) && (state_q != S_HOP_SYNC);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hop_n_q    <= '0;
      phase_q    <= '0;
      sync_len_q <= '0;
      num_hops_q <= '0;
      start_ph_q <= '0;
      dph_q      <= '0;
      hop_rst_q  <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hop_n_q    <= hop_n_d;
      phase_q    <= phase_d;
      sync_len_q <= sync_len_d;
      num_hops_q <= num_hops_d;
      start_ph_q <= start_ph_d;
      dph_q      <= dph_d;
      hop_rst_q  <= hop_rst_d;
      seq_done_q <= seq_done_d;
    end
  end

  // NOTE: the table has no reset so it maps onto plain RAM; its contents are owned by software.
  always_ff @(posedge clk) begin
    if (tbl_wr_en) tbl_q[tbl_wr_addr] <= tbl_wr_data;
  end

  // hop_code is frozen while idle so an abort leaves the last code visible.
  always_ff @(posedge clk) begin
    if (reset)                  code_q <= '0;
    else if (state_q != S_IDLE) code_q <= tbl_q[hop_n_q];
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    sync_out = (state_q == S_LOC_SYNC) || (state_q == S_HOP_SYNC);
    tx_blank = (state_q == S_HOP_SYNC) && (cnt_q < (sync_len_q >> 2));
  end

  assign state         = state_q;
  assign hop_n         = hop_n_q;
  assign hop_phase_inc = phase_q;
  assign hop_code      = code_q;
  assign hop_rst       = hop_rst_q;
  assign seq_done      = seq_done_q;

endmodule

// File: tb/tb_hop_seq_ctrl.sv
// Scoreboard bench for hop_seq_ctrl: expected hop phases/codes are queued at stimulus time and popped on each hop_rst.
// Define HOP_SEQ_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES = 100 here).

module tb_hop_seq_ctrl;

  localparam int PW = 24;
  localparam int CW = 32;
  localparam int AW = 6;
  localparam int SW = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOC = 2'd1, S_HSYNC = 2'd2, S_HTX = 2'd3;
  localparam logic [CW-1:0] NEW_CODE = 32'h5A5A_1111;

  logic          clk = 1'b0;
  logic          reset, start, stop, loop_en, tbl_wr_en, hop_done;
  logic [AW:0]   cfg_num_hops;
  logic [SW-1:0] cfg_sync_len;
  logic [PW-1:0] cfg_start_ph_inc, cfg_dph_inc;
  logic [AW-1:0] tbl_wr_addr;
  logic [CW-1:0] tbl_wr_data;
  logic [1:0]    state;
  logic [AW-1:0] hop_n;
  logic [PW-1:0] hop_phase_inc;
  logic [CW-1:0] hop_code;
  logic          hop_rst, tx_blank, sync_out, busy, seq_done, err;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_phase_q [$];
  logic [CW-1:0] exp_code_q  [$];

  int n_rst, n_seq, n_loc, n_tx, n_blank, loc_len, hs_len_first;
  int bad_blank, bad_sync, bad_busy;
  bit idle_seen;

  hop_seq_ctrl #(
    .PHASE_WIDTH(PW), .CODE_WIDTH(CW), .HOP_ADDR_WIDTH(AW),
    .SYNC_LEN_WIDTH(SW), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .cfg_num_hops(cfg_num_hops), .cfg_sync_len(cfg_sync_len),
    .cfg_start_ph_inc(cfg_start_ph_inc), .cfg_dph_inc(cfg_dph_inc),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .hop_done(hop_done), .state(state), .hop_n(hop_n), .hop_phase_inc(hop_phase_inc),
    .hop_code(hop_code), .hop_rst(hop_rst), .tx_blank(tx_blank), .sync_out(sync_out),
    .busy(busy), .seq_done(seq_done), .err(err)
  );

  always #5 clk = ~clk;

  // Call right after a negedge; start is dropped by the next monitor/driver cycle.
  task automatic start_seq(input int nh, input int sl, input logic [PW-1:0] ph0,
                           input logic [PW-1:0] dph, input logic lp);
    cfg_num_hops     = (AW + 1)'(nh);
    cfg_sync_len     = SW'(sl);
    cfg_start_ph_inc = ph0;
    cfg_dph_inc      = dph;
    loop_en          = lp;
    start            = 1'b1;
  endtask

  task automatic push_phases(input int n, input logic [PW-1:0] ph0, input logic [PW-1:0] dph);
    logic [PW-1:0] p;
    p = ph0;
    for (int i = 0; i < n; i++) begin
      exp_phase_q.push_back(p);
      p = p + dph;
    end
  endtask

  task automatic write_tbl(input int addr, input logic [CW-1:0] data);
    @(negedge clk);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = AW'(addr);
    tbl_wr_data = data;
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  // Cycle monitor: answers HOP_TX with hop_done after hop_delay cycles (0 = never),
  // pops the scoreboards on hop_rst and tallies timing/blanking behaviour.
  task automatic monitor(input int max_cycles, input int hop_delay, input int exp_sl,
                         input bit until_idle, input bit rewrite);
    logic [1:0] prev_state;
    logic [PW-1:0] ep;
    logic [CW-1:0] ec;
    int k, tx_cyc, rw_step;
    bit code_due, exp_blank, exp_sync;
    prev_state = S_IDLE;
    k = 0; tx_cyc = 0; rw_step = 0; code_due = 0;
    n_rst = 0; n_seq = 0; n_loc = 0; n_tx = 0; n_blank = 0; loc_len = 0; hs_len_first = -1;
    bad_blank = 0; bad_sync = 0; bad_busy = 0; idle_seen = 0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      start = 1'b0; hop_done = 1'b0; tbl_wr_en = 1'b0;
      if (rw_step == 2) begin
        checks++;
        if (hop_code !== NEW_CODE) begin
          $display("FAIL table_rewrite: hop_code=%h expected=%h", hop_code, NEW_CODE);
          errors++;
        end
        rw_step = 0;
      end else if (rw_step == 1) begin
        rw_step = 2;
      end
      if (code_due) begin
        code_due = 0;
        if (exp_code_q.size() > 0) begin
          ec = exp_code_q.pop_front();
          checks++;
          if (hop_code !== ec) begin
            $display("FAIL hop_code hop %0d: got=%h expected=%h", hop_n, hop_code, ec);
            errors++;
          end
          if (rewrite && hop_n == AW'(1)) begin
            tbl_wr_en = 1'b1; tbl_wr_addr = AW'(1); tbl_wr_data = NEW_CODE;
            rw_step = 1;
          end
        end
      end
      if (hop_rst) begin
        n_rst++;
        code_due = 1;
        checks++;
        if (state !== S_HSYNC) begin
          $display("FAIL hop_rst_state: state=%0d expected=%0d", state, S_HSYNC);
          errors++;
        end
        if (exp_phase_q.size() > 0) begin
          ep = exp_phase_q.pop_front();
          checks++;
          if (hop_phase_inc !== ep) begin
            $display("FAIL hop_phase hop %0d: got=%h expected=%h", hop_n, hop_phase_inc, ep);
            errors++;
          end
        end
      end
      if (seq_done) n_seq++;
      if (busy !== (state != S_IDLE)) bad_busy++;
      exp_sync = (state == S_LOC) || (state == S_HSYNC);
      if (sync_out !== exp_sync) bad_sync++;
      if (state == S_HSYNC) begin
        k = (prev_state != S_HSYNC) ? 0 : k + 1;
        exp_blank = (k >= exp_sl - exp_sl / 4);
      end else begin
        exp_blank = 0;
        if (prev_state == S_HSYNC && hs_len_first < 0) hs_len_first = k + 1;
      end
      if (tx_blank !== exp_blank) bad_blank++;
      if (tx_blank === 1'b1) n_blank++;
      if (state == S_LOC) begin
        if (prev_state != S_LOC) n_loc++;
        if (n_loc == 1) loc_len++;
      end
      if (state == S_HTX) begin
        n_tx++;
        tx_cyc = (prev_state != S_HTX) ? 0 : tx_cyc + 1;
        if (hop_delay > 0 && tx_cyc == hop_delay - 1) hop_done = 1'b1;
      end
      prev_state = state;
      if (until_idle && state == S_IDLE) begin
        idle_seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({state, hop_n, hop_phase_inc, hop_code, hop_rst, tx_blank, sync_out, busy, seq_done, err} !== '0) begin
      $display("FAIL reset_outputs: state=%0d hop_n=%0d ph=%h code=%h rst=%b blank=%b sync=%b busy=%b done=%b err=%b",
               state, hop_n, hop_phase_inc, hop_code, hop_rst, tx_blank, sync_out, busy, seq_done, err);
      errors++;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== S_IDLE || busy !== 1'b0) begin
      $display("FAIL post_reset_idle: state=%0d busy=%b expected 0/0", state, busy);
      errors++;
    end
  endtask

  task automatic test_single_shot;
    @(negedge clk);
    push_phases(3, 24'hC00000, 24'h020000);
    start_seq(3, 16, 24'hC00000, 24'h020000, 1'b0);
    monitor(400, 5, 16, 1, 0);
    checks++;
    if (!idle_seen || n_rst != 3 || n_seq != 1) begin
      $display("FAIL single_shot: idle=%0d hop_rst=%0d seq_done=%0d expected 1/3/1", idle_seen, n_rst, n_seq);
      errors++;
    end
    checks++;
    if (exp_phase_q.size() != 0 || bad_busy != 0 || busy !== 1'b0) begin
      $display("FAIL single_shot_end: left=%0d bad_busy=%0d busy=%b expected 0/0/0",
               exp_phase_q.size(), bad_busy, busy);
      errors++;
      exp_phase_q.delete();
    end
  endtask

  task automatic test_blanking;
    @(negedge clk);
    start_seq(1, 16, 24'h000100, 24'h000001, 1'b0);
    monitor(200, 5, 16, 1, 0);
    checks++;
    if (loc_len != 16 || hs_len_first != 16) begin
      $display("FAIL sync_lengths: loc=%0d hop_sync=%0d expected 16/16", loc_len, hs_len_first);
      errors++;
    end
    checks++;
    if (bad_blank != 0 || n_blank != 4 || bad_sync != 0) begin
      $display("FAIL blanking: bad_blank=%0d blank_cycles=%0d bad_sync=%0d expected 0/4/0",
               bad_blank, n_blank, bad_sync);
      errors++;
    end
  endtask

  task automatic test_table;
    for (int i = 0; i < 3; i++) begin
      write_tbl(i, 32'hA5A5_0000 + CW'(i));
      exp_code_q.push_back(32'hA5A5_0000 + CW'(i));
    end
    @(negedge clk);
    start_seq(3, 16, 24'h010000, 24'h000800, 1'b0);
    monitor(400, 5, 16, 1, 1);
    checks++;
    if (!idle_seen || exp_code_q.size() != 0 || n_rst != 3) begin
      $display("FAIL table_run: idle=%0d codes_left=%0d hop_rst=%0d expected 1/0/3",
               idle_seen, exp_code_q.size(), n_rst);
      errors++;
      exp_code_q.delete();
    end
  endtask

  task automatic test_loop_limits;
    @(negedge clk);
    start_seq(1, 2, 24'h0A0000, 24'h000100, 1'b1);
    monitor(60, 3, 4, 0, 0);
    checks++;
    if (n_loc < 3 || n_rst < 3 || n_seq != 0 || loc_len != 4 || bad_blank != 0) begin
      $display("FAIL loop: loc_entries=%0d hop_rst=%0d seq_done=%0d loc_len=%0d bad_blank=%0d expected >=3/>=3/0/4/0",
               n_loc, n_rst, n_seq, loc_len, bad_blank);
      errors++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; hop_done = 1'b0;
    checks++;
    if (state !== S_IDLE || seq_done !== 1'b0) begin
      $display("FAIL loop_stop: state=%0d seq_done=%b expected 0/0", state, seq_done);
      errors++;
    end
    // zero hops behaves as one
    push_phases(1, 24'h000040, 24'h000010);
    start_seq(0, 4, 24'h000040, 24'h000010, 1'b0);
    monitor(200, 2, 4, 1, 0);
    checks++;
    if (!idle_seen || n_rst != 1 || n_seq != 1 || exp_phase_q.size() != 0) begin
      $display("FAIL zero_hops: idle=%0d hop_rst=%0d seq_done=%0d left=%0d expected 1/1/1/0",
               idle_seen, n_rst, n_seq, exp_phase_q.size());
      errors++;
      exp_phase_q.delete();
    end
    // oversize hop count saturates at table depth; phase wraps modulo 2**24
    @(negedge clk);
    push_phases(64, 24'hF00000, 24'h080000);
    start_seq(100, 4, 24'hF00000, 24'h080000, 1'b0);
    monitor(2000, 1, 4, 1, 0);
    checks++;
    if (!idle_seen || n_rst != 64 || n_seq != 1 || exp_phase_q.size() != 0) begin
      $display("FAIL saturate_hops: idle=%0d hop_rst=%0d seq_done=%0d left=%0d expected 1/64/1/0",
               idle_seen, n_rst, n_seq, exp_phase_q.size());
      errors++;
      exp_phase_q.delete();
    end
  endtask

  task automatic test_abort_priority;
    bit found;
    found = 0;
    @(negedge clk);
    start_seq(3, 8, 24'h100000, 24'h000100, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0; hop_done = 1'b0;
      if (state == S_HTX && hop_n == AW'(1)) begin
        found = 1;
        break;
      end
      if (state == S_HTX) hop_done = 1'b1;
    end
    checks++;
    if (!found) begin
      $display("FAIL reach_hop1_tx: timed out, state=%0d hop_n=%0d", state, hop_n);
      errors++;
    end
    stop = 1'b1; hop_done = 1'b1;
    @(negedge clk);
    stop = 1'b0; hop_done = 1'b0;
    checks++;
    if (state !== S_IDLE || hop_n !== '0 || seq_done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL stop_with_hop_done: state=%0d hop_n=%0d seq_done=%b busy=%b expected 0/0/0/0",
               state, hop_n, seq_done, busy);
      errors++;
    end
    checks++;
    if (hop_phase_inc !== 24'h100100 || tx_blank !== 1'b0 || sync_out !== 1'b0) begin
      $display("FAIL stop_hold: phase=%h blank=%b sync=%b expected 100100/0/0", hop_phase_inc, tx_blank, sync_out);
      errors++;
    end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; hop_done = 1'b1;
    checks++;
    if (state !== S_IDLE || busy !== 1'b0) begin
      $display("FAIL start_with_stop: state=%0d busy=%b expected 0/0", state, busy);
      errors++;
    end
    @(negedge clk);
    hop_done = 1'b0;
    checks++;
    if (state !== S_IDLE || seq_done !== 1'b0) begin
      $display("FAIL hop_done_in_idle: state=%0d seq_done=%b expected 0/0", state, seq_done);
      errors++;
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 0;
    write_tbl(1, 32'h1234_ABCD);
    @(negedge clk);
    start_seq(2, 8, 24'h123456, 24'h000010, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0; hop_done = 1'b0;
      if (state == S_HSYNC && hop_n == AW'(1)) begin
        found = 1;
        break;
      end
      if (state == S_HTX) hop_done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (!found || hop_code !== 32'h1234_ABCD) begin
      $display("FAIL pre_reset_hop1: found=%0d hop_code=%h expected 1/1234abcd", found, hop_code);
      errors++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({state, hop_n, hop_phase_inc, hop_code, hop_rst, tx_blank, sync_out, busy, seq_done} !== '0) begin
      $display("FAIL reset_mid: state=%0d hop_n=%0d ph=%h code=%h busy=%b sync=%b expected all 0",
               state, hop_n, hop_phase_inc, hop_code, busy, sync_out);
      errors++;
    end
  endtask

`ifdef HOP_SEQ_TIMEOUT_EN
  task automatic test_watchdog;
    @(negedge clk);
    start_seq(1, 4, 24'h000200, 24'h000001, 1'b0);
    monitor(400, 0, 4, 1, 0);
    checks++;
    if (!idle_seen || n_tx != 100 || n_seq != 0) begin
      $display("FAIL watchdog: idle=%0d tx_cycles=%0d seq_done=%0d expected 1/100/0", idle_seen, n_tx, n_seq);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      $display("FAIL err_sticky: err=%b expected 1", err);
      errors++;
    end
    start_seq(1, 4, 24'h000200, 24'h000001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL err_clear_on_start: err=%b busy=%b expected 0/1", err, busy);
      errors++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask
`else
  task automatic test_watchdog;
    @(negedge clk);
    start_seq(1, 4, 24'h000200, 24'h000001, 1'b0);
    monitor(400, 0, 4, 1, 0);
    checks++;
    if (idle_seen || state !== S_HTX || err !== 1'b0) begin
      $display("FAIL no_watchdog: idle=%0d state=%0d err=%b expected 0/3/0", idle_seen, state, err);
      errors++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; hop_done = 1'b0;
    cfg_num_hops = '0; cfg_sync_len = '0; cfg_start_ph_inc = '0; cfg_dph_inc = '0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    test_reset();
    test_single_shot();
    test_blanking();
    test_table();
    test_loop_limits();
    test_abort_priority();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hop_seq_ctrl.md
Name: hop_seq_ctrl

Overview:
Parametrised frequency-hop sequencer for the tag-chip TX path. It sequences a local-sync preamble, then a per-hop sync/blank interval, then a TX interval per hop. Hop count, sync length, start phase increment and phase step are set at runtime. Hop codes come from a writable table that replaces the fixed file-loaded ROM. It drives the hop scan-chain reset, the TX blanking and the sync GPIO bit, and consumes hop_done from the signal generator.

Parameters:
PHASE_WIDTH, 24, width of phase increment
CODE_WIDTH, 32, width of one hop code table entry
HOP_ADDR_WIDTH, 6, table depth = 2**HOP_ADDR_WIDTH; max hops
SYNC_LEN_WIDTH, 16, width of sync interval counter
TIMEOUT_CYCLES, 1048576, HOP_TX watchdog limit (used only with macro)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle start request; honoured only in IDLE
stop  in  1  abort; returns to IDLE next cycle
loop_en  in  1  1 = restart at LOC_SYNC after last hop; 0 = single shot
cfg_num_hops  in  HOP_ADDR_WIDTH+1  hops per sequence; latched on start
cfg_sync_len  in  SYNC_LEN_WIDTH  sync interval length in cycles; latched on start
cfg_start_ph_inc  in  PHASE_WIDTH  phase increment of hop 0; latched on start
cfg_dph_inc  in  PHASE_WIDTH  per-hop phase increment step; latched on start
tbl_wr_en  in  1  hop table write strobe
tbl_wr_addr  in  HOP_ADDR_WIDTH  table write address
tbl_wr_data  in  CODE_WIDTH  table write data
hop_done  in  1  one-cycle pulse from signal generator: hop TX finished
state  out  2  0 IDLE, 1 LOC_SYNC, 2 HOP_SYNC, 3 HOP_TX
hop_n  out  HOP_ADDR_WIDTH  current hop index
hop_phase_inc  out  PHASE_WIDTH  phase increment of current hop
hop_code  out  CODE_WIDTH  table[hop_n], registered
hop_rst  out  1  one-cycle pulse on each entry to HOP_SYNC
tx_blank  out  1  force IQ to zero / hold signal generator in reset
sync_out  out  1  sync GPIO bit
busy  out  1  state != IDLE
seq_done  out  1  one-cycle pulse when a single-shot sequence ends
err  out  1  sticky watchdog error

Behaviour:
- Reset: every output 0; internal counter 0. Table contents are not reset.
- Effective values latched on start:
  - sync_len: max(cfg_sync_len, 4).
  - num_hops: 0 is treated as 1; values above 2**HOP_ADDR_WIDTH saturate to 2**HOP_ADDR_WIDTH.
- IDLE: on start (and stop low), latch config, then:
  - hop_n <= 0, hop_phase_inc <= cfg_start_ph_inc;
  - cnt <= sync_len-1; go to LOC_SYNC.
  - start in any other state is ignored.
- LOC_SYNC: cnt decrements each cycle. At cnt==0: go to HOP_SYNC, cnt <= sync_len-1, hop_rst=1 for that cycle.
- HOP_SYNC: cnt decrements. tx_blank = (cnt < sync_len>>2), combinational from state/cnt. At cnt==0: go to HOP_TX.
- HOP_TX: wait for hop_done.
  - If hop_n < num_hops-1: hop_n++, hop_phase_inc += dph_inc (modulo 2**PHASE_WIDTH, wraps silently), cnt <= sync_len-1, go to HOP_SYNC (hop_rst pulse).
  - Else if loop_en (sampled at that cycle): hop_n <= 0, hop_phase_inc <= start value, cnt <= sync_len-1, go to LOC_SYNC.
  - Else: go to IDLE, seq_done=1 for one cycle.
- hop_done outside HOP_TX is ignored.
- sync_out = 1 in LOC_SYNC and HOP_SYNC, else 0.
- hop_code: synchronous read of table[hop_n], registered, 1-cycle latency after hop_n changes. It is stable for the whole HOP_SYNC/HOP_TX of that hop because sync_len >= 4.
- Table write: accepted every cycle, any state. A write to the address being read shows up on hop_code the cycle after the write.
- stop: highest priority over start and hop_done. Next cycle: state IDLE; hop_n, cnt, tx_blank, sync_out, busy at 0; hop_phase_inc and hop_code hold. No seq_done.
- reset mid-sequence: as reset above.

Optional Feature:
HOP_SEQ_TIMEOUT_EN
- Defined: a watchdog counts cycles in HOP_TX, cleared on entry to HOP_TX.
  - Reaching TIMEOUT_CYCLES without hop_done: go to IDLE and set err=1 (sticky until reset or next accepted start). No seq_done.
  - hop_done in the same cycle as the timeout wins.
- Not defined: no watchdog, HOP_TX waits indefinitely, err tied to 0.

Test Plan:
- Single shot: cfg_num_hops=3, sync_len=16, start_ph_inc=-4194304, dph=131072, hop_done 5 cycles after each HOP_TX entry → 3 hop_rst pulses; hop_phase_inc -4194304, -4063232, -3932160; seq_done once; busy low after.
- Blanking/timing: sync_len=16 → LOC_SYNC 16 cycles; HOP_SYNC 16 cycles with tx_blank high exactly on the last 4; sync_out high over both intervals.
- Table: write table[0..2]=0xA5A5_0000+i, run 3 hops → hop_code equals the written value one cycle after each hop_n change. Rewrite table[1] mid-hop 1 → new value on the next cycle.
- Loop and limits: loop_en=1, num_hops=1, cfg_sync_len=2 → sync_len 4, LOC_SYNC re-entered after each hop_done, never seq_done. cfg_num_hops=0 → exactly 1 hop.
- Abort/priority: stop asserted together with hop_done in HOP_TX → IDLE next cycle, hop_n=0, no seq_done. start and stop together in IDLE → stays IDLE.
- Watchdog (with HOP_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100): no hop_done → IDLE after 100 HOP_TX cycles, err=1. Next start clears err.
